// File: rtl/mmio_peripheral_pkg.sv
// Shared constants for the MEM-stage I/O window: register offsets, TCON bit positions
// and the default window base.
package mmio_peripheral_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

  localparam logic [3:0] OFF_TH      = 4'd0;
  localparam logic [3:0] OFF_TL      = 4'd1;
  localparam logic [3:0] OFF_TCON    = 4'd2;
  localparam logic [3:0] OFF_LED     = 4'd3;
  localparam logic [3:0] OFF_DIGI    = 4'd4;
  localparam logic [3:0] OFF_SYSTICK = 4'd5;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IF = 2;

endpackage

// File: rtl/mmio_peripheral_hex_to_seg.sv
// Hex digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; purely combinational.
module mmio_peripheral_hex_to_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mmio_peripheral.sv
// MEM-stage I/O slave: reloading timer with interrupt flag, LED register, scanned
// 4-digit 7-segment display and a free-running SysTick counter.
module mmio_peripheral
  import mmio_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int unsigned SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        io_sel,
  output logic        irq,
  output logic [7:0]  led,
  output logic [7:0]  BCD,
  output logic [3:0]  AN
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  logic [31:0]     th_q, th_d, tl_q, tl_d, systick_q;
  logic [2:0]      tcon_q, tcon_d;
  logic [7:0]      led_q;
  logic [19:0]     digi_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      bcd_q, bcd_d;
  logic [3:0]      an_q, an_d;

  logic [3:0] offset;
  logic       wr_en, overflow, ovf_set;
  logic [3:0] digit_en;
  logic [6:0] seg;
  logic       unused_addr;

  assign io_sel      = (Address[31:6] == BASE_ADDR[31:6]);
  assign offset      = Address[5:2];
  assign wr_en       = MemWrite & io_sel;
  assign unused_addr = ^Address[1:0];

  always_comb begin
    Read_data = 32'h0;
    if (MemRead && io_sel) begin
      case (offset)
        OFF_TH:      Read_data = th_q;
        OFF_TL:      Read_data = tl_q;
        OFF_TCON:    Read_data = {29'h0, tcon_q};
        OFF_LED:     Read_data = {24'h0, led_q};
        OFF_DIGI:    Read_data = {12'h0, digi_q};
        OFF_SYSTICK: Read_data = systick_q;
        default:     Read_data = 32'h0;
      endcase
    end
  end

  assign overflow = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
  assign ovf_set  = overflow && tcon_q[TCON_IE];

  // A software store to TL beats the counter; a store to TH only affects later reloads.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (wr_en && offset == OFF_TH) th_d = Write_data;
    if (wr_en && offset == OFF_TL) begin
      tl_d = Write_data;
    end else if (overflow) begin
      tl_d = th_q;
    end else if (tcon_q[TCON_EN]) begin
      tl_d = tl_q + 32'd1;
    end
    if (wr_en && offset == OFF_TCON) begin
      tcon_d = {Write_data[TCON_IF] | ovf_set, Write_data[TCON_IE:TCON_EN]};
    end else if (ovf_set) begin
      tcon_d[TCON_IF] = 1'b1;
    end
  end

  assign digit_en = digi_q[19:16];

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntLast) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d  = digit_en[idx_q] ? ~(4'b0001 << idx_q) : 4'hF;
    bcd_d = digit_en[idx_q] ? {1'b1, seg} : 8'hFF;
  end

  mmio_peripheral_hex_to_seg u_hex_to_seg (
    .hex (digi_q[{idx_q, 2'b00} +: 4]),
    .seg (seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      bcd_q     <= 8'hFF;
      an_q      <= 4'hF;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_q + 32'd1;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      bcd_q     <= bcd_d;
      an_q      <= an_d;
      if (wr_en && offset == OFF_LED)  led_q  <= Write_data[7:0];
      if (wr_en && offset == OFF_DIGI) digi_q <= Write_data[19:0];
    end
  end

  assign irq = tcon_q[TCON_IF];
  assign led = led_q;
  assign BCD = bcd_q;
  assign AN  = an_q;

endmodule

// File: tb/tb_mmio_peripheral.sv
// Self-checking bench for mmio_peripheral: reset, timer reload/collision, decode table
// and display scanning with a cycle model feeding a scoreboard queue.
module tb_mmio_peripheral;

  localparam int unsigned ScanDiv = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, Write_data, Read_data;
  logic        MemRead, MemWrite, io_sel, irq;
  logic [7:0]  led, BCD;
  logic [3:0]  AN;

  mmio_peripheral #(
    .BASE_ADDR (32'h4000_0000),
    .SCAN_DIV  (ScanDiv)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .io_sel     (io_sel),
    .irq        (irq),
    .led        (led),
    .BCD        (BCD),
    .AN         (AN)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [11:0] disp_q[$];

  int unsigned m_cnt;
  logic [1:0]  m_idx;
  logic [19:0] m_digi;
  bit          seen_an;
  logic [3:0]  first_an;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_sel;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; the store lands on the following posedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    MemRead    = 1'b0;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  task automatic bus_read(input string nm, input logic [31:0] a, input logic [31:0] e);
    Address = a;
    MemRead = 1'b1;
    exp_q.push_back(e);
    #1;
    chk(nm, Read_data, exp_q.pop_front());
    MemRead = 1'b0;
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tab[h];
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 2'd0;
    m_digi = 20'h0;
  endtask

  // Each cycle: predict pins for the coming edge from the model, advance the model,
  // then compare one negedge later.
  task automatic display_run(input int n, input bit do_wr, input logic [31:0] wval);
    logic [3:0]  e_an;
    logic [7:0]  e_bcd;
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      if (m_digi[16 + m_idx]) begin
        e_an  = ~(4'b0001 << m_idx);
        e_bcd = {1'b1, ref_seg(m_digi[4*m_idx +: 4])};
      end else begin
        e_an  = 4'hF;
        e_bcd = 8'hFF;
      end
      disp_q.push_back({e_an, e_bcd});
      if (do_wr && i == 0) begin
        Address    = 32'h4000_0010;
        Write_data = wval;
        MemWrite   = 1'b1;
        m_digi     = wval[19:0];
      end
      if (m_cnt == ScanDiv - 1) begin
        m_cnt = 0;
        m_idx = m_idx + 2'd1;
      end else begin
        m_cnt++;
      end
      @(negedge clk);
      MemWrite = 1'b0;
      e = disp_q.pop_front();
      chk($sformatf("AN cyc%0d", i), {28'h0, AN}, {28'h0, e[11:8]});
      chk($sformatf("BCD cyc%0d", i), {24'h0, BCD}, {24'h0, e[7:0]});
      if (!seen_an && AN != 4'hF) begin
        seen_an  = 1'b1;
        first_an = AN;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 32'h4000_000C, 32'h0000_00A5, 32'h0,          1'b1};
    tbl[1]  = '{1'b0, 1'b1, 32'h4000_000C, 32'h0,          32'h0000_00A5, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 32'h4000_0040, 32'h0000_00FF, 32'h0,          1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h4000_0018, 32'h0000_00FF, 32'h0,          1'b1};
    tbl[4]  = '{1'b0, 1'b1, 32'h4000_000C, 32'h0,          32'h0000_00A5, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'h4000_0000, 32'h0,          32'hFFFF_FFFC, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h4000_0018, 32'h0,          32'h0,          1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'h4000_000C, 32'h0,          32'h0,          1'b1};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,          32'h0,          1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h4000_0000, 32'h1234_5678, 32'h0,          1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'h4000_0000, 32'h0,          32'h1234_5678, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h4000_0010, 32'hFFFF_FFFF, 32'h0,          1'b1};
    tbl[12] = '{1'b0, 1'b1, 32'h4000_0010, 32'h0,          32'h000F_FFFF, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 32'h4000_0008, 32'hFFFF_FFF8, 32'h0,          1'b1};
    tbl[14] = '{1'b0, 1'b1, 32'h4000_0008, 32'h0,          32'h0,          1'b1};

    // Reset / idle
    repeat (3) @(negedge clk);
    chk("rst led", {24'h0, led}, 32'h0);
    chk("rst BCD", {24'h0, BCD}, 32'hFF);
    chk("rst AN", {28'h0, AN}, 32'hF);
    chk("rst irq", {31'h0, irq}, 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    bus_read("systick", 32'h4000_0014, 32'd10);

    // Timer reload
    bus_write(32'h4000_0000, 32'hFFFF_FFFC);
    bus_write(32'h4000_0004, 32'hFFFF_FFFE);
    bus_write(32'h4000_0008, 32'h3);
    bus_read("tl start", 32'h4000_0004, 32'hFFFF_FFFE);
    chk("irq start", {31'h0, irq}, 32'h0);
    @(negedge clk);
    bus_read("tl max", 32'h4000_0004, 32'hFFFF_FFFF);
    chk("irq pre wrap", {31'h0, irq}, 32'h0);
    @(negedge clk);
    bus_read("tl reload", 32'h4000_0004, 32'hFFFF_FFFC);
    chk("irq wrap", {31'h0, irq}, 32'h1);
    bus_read("tcon flag", 32'h4000_0008, 32'h7);
    bus_write(32'h4000_0008, 32'h3);
    chk("irq clear", {31'h0, irq}, 32'h0);
    bus_read("tcon clear", 32'h4000_0008, 32'h3);
    bus_write(32'h4000_0008, 32'h0);

    // Store to TCON on the overflow edge must not lose the flag
    bus_write(32'h4000_0004, 32'hFFFF_FFFF);
    bus_write(32'h4000_0008, 32'h3);
    bus_write(32'h4000_0008, 32'h3);
    bus_read("collide tcon", 32'h4000_0008, 32'h7);
    chk("collide irq", {31'h0, irq}, 32'h1);
    bus_read("collide tl", 32'h4000_0004, 32'hFFFF_FFFC);
    bus_write(32'h4000_0008, 32'h0);
    chk("irq off", {31'h0, irq}, 32'h0);

    // Decode table
    for (int i = 0; i < 15; i++) begin
      Address    = tbl[i].addr;
      Write_data = tbl[i].data;
      MemWrite   = tbl[i].wr;
      MemRead    = tbl[i].rd;
      if (!tbl[i].wr) exp_q.push_back(tbl[i].exp_rd);
      #1;
      chk($sformatf("io_sel v%0d", i), {31'h0, io_sel}, {31'h0, tbl[i].exp_sel});
      if (!tbl[i].wr) chk($sformatf("rdata v%0d", i), Read_data, exp_q.pop_front());
      @(negedge clk);
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
    chk("led pins", {24'h0, led}, 32'hA5);

    // Display scan from a clean reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    seen_an = 1'b0;
    display_run(24, 1'b1, 32'h0005_1234);
    while (m_idx != 2'd2) display_run(1, 1'b0, 32'h0);

    // Reset during digit 2
    reset = 1'b0;
    #1;
    chk("midscan AN", {28'h0, AN}, 32'hF);
    chk("midscan BCD", {24'h0, BCD}, 32'hFF);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    seen_an = 1'b0;
    display_run(12, 1'b1, 32'h0005_1234);
    chk("first digit", {31'h0, seen_an}, 32'h1);
    chk("first AN", {28'h0, first_an}, 32'hE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
